pattern_serializer: RTL and testbench

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

---
 rtl/pattern_serializer.sv | 125 ++++++++++++
 tb/tb_pattern_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_serializer.sv
// Byte-to-serial pattern shifter with per-bit hold time, selectable bit order and a frame counter.
// Define SER_PARITY_EN to append an even-parity bit after the eight data bits.
module pattern_serializer #(
   parameter int BIT_CYCLES = 1,
   parameter int MSB_FIRST  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_t,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       abort,
   output logic       ser_out,
   output logic       ser_valid,
   output logic       done,
   output logic [7:0] frame_cnt
);

   localparam logic [3:0] LAST_CYC = 4'(BIT_CYCLES - 1);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, PARITY = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

   state_t     state, next_state;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic [3:0] cyc_cnt;
   logic       bit_end;
   logic       accept;
`ifdef SER_PARITY_EN
   logic       parity_bit;
`endif

   assign bit_end = (cyc_cnt == LAST_CYC);
   assign accept  = in_valid & in_ready;

   // All outputs decode registered state, so an asserted rst_n shows up on them at once.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      ser_valid  = 1'b0;
      ser_out    = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = SHIFT;
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = (MSB_FIRST != 0) ? shreg[7] : shreg[0];
            if (abort) next_state = IDLE;
            else if (bit_end && bit_cnt == 3'd7) begin
`ifdef SER_PARITY_EN
               next_state = PARITY;
`else
               next_state = DONE;
`endif
            end
         end
`ifdef SER_PARITY_EN
         PARITY: begin
            ser_valid = 1'b1;
            ser_out   = parity_bit;
            if (abort) next_state = IDLE;
            else if (bit_end) next_state = DONE;
         end
`endif
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= 8'h00;
         bit_cnt   <= 3'd0;
         cyc_cnt   <= 4'd0;
         frame_cnt <= 8'h00;
`ifdef SER_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg   <= data_t;
                  bit_cnt <= 3'd0;
                  cyc_cnt <= 4'd0;
`ifdef SER_PARITY_EN
                  parity_bit <= ^data_t;
`endif
               end
            end
            SHIFT: begin
               if (!abort) begin
                  if (bit_end) begin
                     cyc_cnt <= 4'd0;
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= (MSB_FIRST != 0) ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
                  end else begin
                     cyc_cnt <= cyc_cnt + 4'd1;
                  end
               end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
               if (!abort) cyc_cnt <= bit_end ? 4'd0 : cyc_cnt + 4'd1;
            end
`endif
            DONE: frame_cnt <= frame_cnt + 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: table of frames on an MSB-first/1-cycle instance
// plus hand sequences for LSB-first/3-cycle, abort, reset mid-frame and counter wrap.
module tb_pattern_serializer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] data_a = 8'h00, data_b = 8'h00;
   logic valid_a = 1'b0, valid_b = 1'b0, abort_a = 1'b0, abort_b = 1'b0;
   logic ready_a, ready_b, sout_a, sout_b, sval_a, sval_b, done_a, done_b;
   logic [7:0] cnt_a, cnt_b;

   pattern_serializer #(.BIT_CYCLES(1), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .data_t(data_a), .in_valid(valid_a), .in_ready(ready_a),
      .abort(abort_a), .ser_out(sout_a), .ser_valid(sval_a), .done(done_a), .frame_cnt(cnt_a));

   pattern_serializer #(.BIT_CYCLES(3), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .data_t(data_b), .in_valid(valid_b), .in_ready(ready_b),
      .abort(abort_b), .ser_out(sout_b), .ser_valid(sval_b), .done(done_b), .frame_cnt(cnt_b));

   int total = 0;
   int bad = 0;
   logic [7:0] exp_cnt_a = 8'h00;

   typedef struct {
      logic [7:0] d;
      logic [7:0] stream;   // expected bits in transmission order, first bit at [7]
      logic       par;
      bit         jam;      // keep in_valid high with garbage data during the frame
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reset_outputs_chk();
      chk("rst_ready_a", {7'd0, ready_a}, 8'd1);
      chk("rst_sval_a",  {7'd0, sval_a},  8'd0);
      chk("rst_sout_a",  {7'd0, sout_a},  8'd0);
      chk("rst_done_a",  {7'd0, done_a},  8'd0);
      chk("rst_cnt_a",   cnt_a,           8'h00);
      chk("rst_ready_b", {7'd0, ready_b}, 8'd1);
      chk("rst_sval_b",  {7'd0, sval_b},  8'd0);
      chk("rst_cnt_b",   cnt_b,           8'h00);
   endtask

   // Called at a negedge with dut_a idle; returns at the negedge after the done cycle.
   task automatic frame_a(input logic [7:0] d, input logic [7:0] stream, input logic par,
                          input bit jam, input bit quiet);
      int errs0;
      errs0 = bad;
      chk("ready_a", {7'd0, ready_a}, 8'd1);
      data_a  = d;
      valid_a = 1'b1;
      @(negedge clk);
      if (!jam) valid_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (jam) data_a = 8'($urandom);
         chk("sval_a", {7'd0, sval_a}, 8'd1);
         chk("sout_a", {7'd0, sout_a}, {7'd0, stream[7-i]});
         chk("busy_ready_a", {7'd0, ready_a}, 8'd0);
         @(negedge clk);
      end
`ifdef SER_PARITY_EN
      chk("par_sval_a", {7'd0, sval_a}, 8'd1);
      chk("par_sout_a", {7'd0, sout_a}, {7'd0, par});
      @(negedge clk);
`else
      if (par) ;
`endif
      valid_a = 1'b0;
      chk("done_a",      {7'd0, done_a}, 8'd1);
      chk("done_sval_a", {7'd0, sval_a}, 8'd0);
      chk("done_sout_a", {7'd0, sout_a}, 8'd0);
      exp_cnt_a = exp_cnt_a + 8'd1;
      @(negedge clk);
      chk("post_done_a",  {7'd0, done_a},  8'd0);
      chk("post_ready_a", {7'd0, ready_a}, 8'd1);
      chk("cnt_a",        cnt_a,           exp_cnt_a);
      if (!quiet)
         $display("frame a d=%h jam=%0d cnt=%0d errors=%0d", d, jam, cnt_a, bad - errs0);
   endtask

   initial begin
      vecs[0] = '{d: 8'hAA, stream: 8'b1010_1010, par: 1'b0, jam: 1'b0};
      vecs[1] = '{d: 8'h01, stream: 8'b0000_0001, par: 1'b1, jam: 1'b0};
      vecs[2] = '{d: 8'h55, stream: 8'b0101_0101, par: 1'b0, jam: 1'b1};
      vecs[3] = '{d: 8'hC3, stream: 8'b1100_0011, par: 1'b0, jam: 1'b0};
      vecs[4] = '{d: 8'h80, stream: 8'b1000_0000, par: 1'b1, jam: 1'b1};
      vecs[5] = '{d: 8'h7E, stream: 8'b0111_1110, par: 1'b0, jam: 1'b0};

      #2;
      reset_outputs_chk();
      $display("reset check errors=%0d", bad);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++)
         frame_a(vecs[v].d, vecs[v].stream, vecs[v].par, vecs[v].jam, 1'b0);

      // LSB-first, 3 cycles per bit: F0 gives twelve 0 cycles then twelve 1 cycles
      begin
         int e0;
         e0 = bad;
         data_b  = 8'hF0;
         valid_b = 1'b1;
         @(negedge clk);
         valid_b = 1'b0;
         for (int c = 1; c <= 24; c++) begin
            chk("sval_b", {7'd0, sval_b}, 8'd1);
            chk("sout_b", {7'd0, sout_b}, (c >= 13) ? 8'd1 : 8'd0);
            chk("busy_done_b", {7'd0, done_b}, 8'd0);
            @(negedge clk);
         end
`ifdef SER_PARITY_EN
         for (int c = 0; c < 3; c++) begin
            chk("par_sval_b", {7'd0, sval_b}, 8'd1);
            chk("par_sout_b", {7'd0, sout_b}, 8'd0);
            @(negedge clk);
         end
`endif
         chk("done_b", {7'd0, done_b}, 8'd1);
         @(negedge clk);
         chk("ready_b", {7'd0, ready_b}, 8'd1);
         chk("cnt_b", cnt_b, 8'h01);
         $display("frame b d=F0 errors=%0d", bad - e0);
      end

      // Abort while the fourth bit (bit_cnt 3) of 8'h55 is on the line
      begin
         int e0;
         e0 = bad;
         data_a  = 8'h55;
         valid_a = 1'b1;
         @(negedge clk);
         valid_a = 1'b0;
         repeat (3) @(negedge clk);
         chk("abort_bit3", {7'd0, sout_a}, 8'd1);
         abort_a = 1'b1;
         @(negedge clk);
         abort_a = 1'b0;
         chk("abort_sval", {7'd0, sval_a}, 8'd0);
         chk("abort_ready", {7'd0, ready_a}, 8'd1);
         chk("abort_done", {7'd0, done_a}, 8'd0);
         for (int c = 0; c < 10; c++) begin
            chk("abort_no_done", {7'd0, done_a}, 8'd0);
            @(negedge clk);
         end
         chk("abort_cnt", cnt_a, exp_cnt_a);
         $display("abort a d=55 errors=%0d", bad - e0);
      end

      // Asynchronous reset in the middle of a frame, away from any clock edge
      begin
         int e0;
         e0 = bad;
         data_a  = 8'hFF;
         valid_a = 1'b1;
         data_b  = 8'hFF;
         valid_b = 1'b1;
         @(negedge clk);
         valid_a = 1'b0;
         valid_b = 1'b0;
         repeat (2) @(negedge clk);
         chk("pre_rst_sval", {7'd0, sval_a}, 8'd1);
         #2 rst_n = 1'b0;
         #1;
         reset_outputs_chk();
         exp_cnt_a = 8'h00;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         $display("midframe reset errors=%0d", bad - e0);
      end

      // 256 back-to-back frames wrap the counter to zero
      begin
         int e0;
         e0 = bad;
         for (int f = 0; f < 256; f++) begin
            logic [7:0] d;
            d = 8'(f * 37 + 11);
            frame_a(d, d, ^d, 1'b0, 1'b1);
            $display("bulk frame %0d d=%h cnt=%0d", f, d, cnt_a);
         end
         chk("wrap_cnt", cnt_a, 8'h00);
         $display("wrap after 256 frames errors=%0d", bad - e0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
